// File: rtl/key_debounce_bank_if.sv
// key_debounce_bank_if
//   Groups the per-channel key pins and conditioned key events of
//   key_debounce_bank into one bundle.
//   master : drives raw keys and repeat enables, receives events
//   slave  : the debounce bank itself
//
//   key       raw asynchronous key pins
//   repeat_en per-channel auto-repeat enable (synchronous to clk)
//   level     debounced state, 1 = pressed
//   press     one-cycle pulse on accepted press
//   rel       one-cycle pulse on accepted release ("release" is a reserved word)
//   long      one-cycle pulse when a hold reaches the long-press time
//   rpt       one-cycle auto-repeat pulses after long
interface key_debounce_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] key;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] rel;
    logic [CHANNELS-1:0] long;
    logic [CHANNELS-1:0] rpt;

    modport master (
        output key,
        output repeat_en,
        input  level,
        input  press,
        input  rel,
        input  long,
        input  rpt
    );

    modport slave (
        input  key,
        input  repeat_en,
        output level,
        output press,
        output rel,
        output long,
        output rpt
    );
endinterface

// File: rtl/key_debounce_bank.sv
// key_debounce_bank
//   Multi-channel key conditioner: per channel a 2-flop synchroniser,
//   a glitch-rejecting debounce counter and a long-press / auto-repeat
//   engine. All outputs are registered.
//
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    key_debounce_bank_if.slave (key, repeat_en in; level, press,
//          rel, long, rpt out)
//
// Hold FSM (one per channel)
//   state      | meaning
//   ST_IDLE    | key not pressed, hold counter parked at 0
//   ST_PRESSED | press accepted, counting up to the long-press time
//   ST_HELD    | long issued, counter wraps every REPEAT_CYCLES
module key_debounce_bank #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter bit ACTIVE_HIGH     = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    key_debounce_bank_if.slave  bus
);

    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } hold_state_t;

    logic [CHANNELS-1:0] key_norm;

    logic [CHANNELS-1:0] s1_q, s1_d;
    logic [CHANNELS-1:0] s2_q, s2_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] rel_q, rel_d;
    logic [CHANNELS-1:0] long_q, long_d;
    logic [CHANNELS-1:0] rpt_q, rpt_d;

    logic [CNT_W-1:0]  cnt_q   [CHANNELS];
    logic [CNT_W-1:0]  cnt_d   [CHANNELS];
    logic [HOLD_W-1:0] hold_q  [CHANNELS];
    logic [HOLD_W-1:0] hold_d  [CHANNELS];
    hold_state_t       state_q [CHANNELS];
    hold_state_t       state_d [CHANNELS];

    // Normalise polarity up front so every flop downstream means "pressed".
    assign key_norm = ACTIVE_HIGH ? bus.key : ~bus.key;

    always_comb begin
        s1_d    = key_norm;
        s2_d    = s1_q;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        long_d  = '0;
        rpt_d   = '0;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        state_d = state_q;

        for (int i = 0; i < CHANNELS; i++) begin
            // Any sample agreeing with the accepted level restarts the count.
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_d[i]   = '0;
                level_d[i] = ~level_q[i];
                press_d[i] = ~level_q[i];
                rel_d[i]   = level_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            // A release accepted this cycle pre-empts long/rpt.
            case (state_q[i])
                ST_IDLE: begin
                    if (press_d[i]) begin
                        state_d[i] = ST_PRESSED;
                        hold_d[i]  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (rel_d[i]) begin
                        state_d[i] = ST_IDLE;
                        hold_d[i]  = '0;
                    end else if (hold_q[i] == HOLD_W'(LONG_CYCLES - 1)) begin
                        state_d[i] = ST_HELD;
                        hold_d[i]  = '0;
                        long_d[i]  = 1'b1;
                    end else begin
                        hold_d[i] = hold_q[i] + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (rel_d[i]) begin
                        state_d[i] = ST_IDLE;
                        hold_d[i]  = '0;
                    end else if (hold_q[i] == HOLD_W'(REPEAT_CYCLES - 1)) begin
                        // Counter runs regardless of repeat_en so the
                        // repeat phase never shifts when it is toggled.
                        hold_d[i] = '0;
                        rpt_d[i]  = bus.repeat_en[i];
                    end else begin
                        hold_d[i] = hold_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    hold_d[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            rpt_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign bus.level = level_q;
    assign bus.press = press_q;
    assign bus.rel   = rel_q;
    assign bus.long  = long_q;
    assign bus.rpt   = rpt_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// tb_key_debounce_bank
//   Two instances of key_debounce_bank (active-high and active-low keys)
//   fed with the same logical stimulus. Expected pulses are queued with
//   their absolute cycle number when stimulus is applied and compared
//   against both instances on every falling edge.
module tb_key_debounce_bank;

    localparam int CH  = 2;
    localparam int DB  = 4;
    localparam int LNG = 20;
    localparam int REP = 8;
    localparam int LAT = DB + 2;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_RPT   = 3;

    typedef struct {
        int         cyc;
        logic [7:0] ev;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] key_v;
    logic [CH-1:0] repeat_v;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    exp_t          exp_q[$];

    key_debounce_bank_if #(.CHANNELS(CH)) if_hi ();
    key_debounce_bank_if #(.CHANNELS(CH)) if_lo ();

    assign if_hi.key       = key_v;
    assign if_lo.key       = ~key_v;
    assign if_hi.repeat_en = repeat_v;
    assign if_lo.repeat_en = repeat_v;

    key_debounce_bank #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LNG),
        .REPEAT_CYCLES(REP), .ACTIVE_HIGH(1'b1)
    ) u_dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_hi)
    );

    key_debounce_bank #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LNG),
        .REPEAT_CYCLES(REP), .ACTIVE_HIGH(1'b0)
    ) u_dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] ev(input int kind, input int ch);
        logic [7:0] v;
        v = '0;
        v[kind*2 + ch] = 1'b1;
        return v;
    endfunction

    task automatic push(input int c, input logic [7:0] e);
        exp_t x;
        x.cyc = c;
        x.ev  = e;
        exp_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: outputs from edge 'cyc' are stable at the following negedge.
    always @(negedge clk) begin
        logic [7:0] exp_ev;
        logic [7:0] obs_hi;
        logic [7:0] obs_lo;
        exp_ev = '0;
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            if (exp_q[0].cyc == cyc) exp_ev |= exp_q[0].ev;
            else check_val("missed_event", 32'd0, {24'd0, exp_q[0].ev});
            void'(exp_q.pop_front());
        end
        obs_hi = {if_hi.rpt, if_hi.long, if_hi.rel, if_hi.press};
        obs_lo = {if_lo.rpt, if_lo.long, if_lo.rel, if_lo.press};
        if (obs_hi != 0 || exp_ev != 0) check_val("events_hi", {24'd0, obs_hi}, {24'd0, exp_ev});
        if (obs_lo != 0 || exp_ev != 0) check_val("events_lo", {24'd0, obs_lo}, {24'd0, exp_ev});
    end

    // Press channel 0 now, drop it drop_at cycles after the press pulse;
    // repeat_en[0] is high for edges whose offset from press lies in
    // [en_from, en_to].
    task automatic hold_ch0(input int drop_at, input int en_from, input int en_to);
        int p;
        int r;
        p = cyc + LAT;
        r = p + drop_at + LAT;
        key_v[0] = 1'b1;
        push(p, ev(K_PRESS, 0));
        if (p + LNG < r) begin
            push(p + LNG, ev(K_LONG, 0));
            for (int k = 1; p + LNG + REP * k < r; k++) begin
                if (LNG + REP * k >= en_from && LNG + REP * k <= en_to)
                    push(p + LNG + REP * k, ev(K_RPT, 0));
            end
        end
        push(r, ev(K_REL, 0));
        while (cyc < p + drop_at) begin
            repeat_v[0] = (cyc + 1 - p >= en_from) && (cyc + 1 - p <= en_to);
            step(1);
            if (cyc == p - 1) check_val("level_early", {30'd0, if_hi.level[0], if_lo.level[0]}, 32'd0);
            if (cyc == p) begin
                check_val("level_hi", {30'd0, if_hi.level}, 32'd1);
                check_val("level_lo", {30'd0, if_lo.level}, 32'd1);
            end
        end
        key_v[0]    = 1'b0;
        repeat_v[0] = 1'b0;
        while (cyc < r + 2) step(1);
        check_val("level_released", {30'd0, if_hi.level[0], if_lo.level[0]}, 32'd0);
    endtask

    initial begin
        int p;
        int last;
        int w;

        rst_n    = 1'b0;
        key_v    = '0;
        repeat_v = '0;
        step(3);
        check_val("reset_level_hi", {30'd0, if_hi.level}, 32'd0);
        check_val("reset_level_lo", {30'd0, if_lo.level}, 32'd0);
        rst_n = 1'b1;
        step(5);

        // Clean press, released before long.
        hold_ch0(4, 1000, 0);
        step(5);

        // Bounce shorter than the debounce window, then stable press.
        for (int i = 0; i < 10; i++) begin
            key_v[0] = ~key_v[0];
            step(3);
        end
        key_v[0] = 1'b1;
        last = cyc;
        push(last + LAT, ev(K_PRESS, 0));
        step(8);
        key_v[0] = 1'b0;
        push(cyc + LAT, ev(K_REL, 0));
        step(12);

        // Long hold with repeat always enabled.
        hold_ch0(44, 0, 1000);
        step(5);
        // Repeat enabled only around the second wrap.
        hold_ch0(44, 30, 38);
        step(5);
        // Release accepted exactly on a repeat wrap: rpt suppressed.
        hold_ch0(30, 0, 1000);
        step(5);
        // Release before long.
        hold_ch0(10, 0, 1000);
        step(5);

        // Both channels pressed together; ch1 released early; ch0 released
        // on its first repeat wrap.
        repeat_v = '1;
        key_v    = 2'b11;
        p = cyc + LAT;
        push(p, ev(K_PRESS, 0) | ev(K_PRESS, 1));
        push(p + 10 + LAT, ev(K_REL, 1));
        push(p + LNG, ev(K_LONG, 0));
        push(p + 22 + LAT, ev(K_REL, 0));
        step(p - cyc);
        check_val("level_both", {30'd0, if_hi.level & if_lo.level}, 32'd3);
        step(10);
        key_v[1] = 1'b0;
        step(12);
        key_v[0] = 1'b0;
        step(12);
        repeat_v = '0;
        step(3);

        // Reset in the middle of a hold with the key still down.
        key_v[0] = 1'b1;
        p = cyc + LAT;
        push(p, ev(K_PRESS, 0));
        step(p + 15 - cyc);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_level_hi", {30'd0, if_hi.level}, 32'd0);
        check_val("rst_mid_level_lo", {30'd0, if_lo.level}, 32'd0);
        check_val("rst_mid_pulses", {24'd0, if_hi.press, if_hi.rel, if_hi.long, if_hi.rpt}, 32'd0);
        step(3);
        rst_n = 1'b1;
        p = cyc + LAT;
        push(p, ev(K_PRESS, 0));
        push(p + LNG, ev(K_LONG, 0));
        push(p + 24 + LAT, ev(K_REL, 0));
        step(p + 24 - cyc);
        key_v[0] = 1'b0;
        step(12);

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            step(1);
            w++;
        end
        check_val("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_bank.md
# key_debounce_bank

Parametrised multi-channel key conditioner placed between raw push-button / switch pins and the control FSMs. Each channel has its own input synchroniser, a glitch-rejecting debounce counter and a per-channel long-press / auto-repeat engine. It replaces single-key debouncers wherever more than one key, press/release events or hold detection are needed.

## Interface
- CHANNELS, 4, number of independent key channels (>=1)
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (>=1)
- LONG_CYCLES, 50000000, cycles from press pulse to long-press pulse (>=2)
- REPEAT_CYCLES, 10000000, auto-repeat period after long-press (>=2)
- ACTIVE_HIGH, 1, 1: raw key=1 means pressed; 0: raw key=0 means pressed
- clk  input  1  single system clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- key  input  CHANNELS  raw asynchronous key pins
- repeat_en  input  CHANNELS  per-channel auto-repeat enable, synchronous to clk
- level  output  CHANNELS  debounced state, 1 = pressed (polarity-normalised)
- press  output  CHANNELS  one-cycle pulse on accepted press
- release  output  CHANNELS  one-cycle pulse on accepted release
- long  output  CHANNELS  one-cycle pulse when hold reaches LONG_CYCLES
- rpt  output  CHANNELS  one-cycle auto-repeat pulses after long

## Operation
- Raw key normalised by ACTIVE_HIGH, then 2-flop synchroniser (s1, s2) per channel; sync flops reset to "not pressed".
- Debounce per channel: counter cnt, width $clog2(DEBOUNCE_CYCLES+1). If s2 == level: cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1: level toggles, cnt <= 0. Else cnt <= cnt+1. Any single sample equal to level restarts the count (glitch rejection).
- press/release: registered on the same edge level toggles (0->1 press, 1->0 release); high exactly one cycle.
- Hold FSM per channel: IDLE -> PRESSED on press; PRESSED -> HELD on long; PRESSED or HELD -> IDLE on release.
- Hold counter (width $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1)): cleared on press, increments each cycle in PRESSED; long pulses when count reaches LONG_CYCLES-1, counter cleared on entering HELD.
- In HELD: counter wraps every REPEAT_CYCLES; rpt pulses at each wrap only if repeat_en is high that cycle. Counter keeps running while repeat_en is low, so toggling repeat_en never shifts phase.
- Release before long: no long, no rpt. release cycle never carries long or rpt; FSM returns to IDLE, counter cleared.
- Channels fully independent; simultaneous events on different channels all reported same cycle.

## Timing
- Reset (async assert): s1, s2 = not pressed, level/press/release/long/rpt = 0, cnt = 0, FSM = IDLE, hold counter = 0.
- Stable change first sampled by edge 1 -> level and press/release valid after edge DEBOUNCE_CYCLES+2.
- long asserted exactly LONG_CYCLES cycles after press asserted; rpt pulses at LONG_CYCLES + k*REPEAT_CYCLES (k>=1) after press.
- repeat_en has no latency beyond sampling in the wrap cycle.
- Key held through reset deassertion: treated as new press, press after DEBOUNCE_CYCLES+2 cycles; long timed from that press.
- Reset mid-hold: all outputs 0 immediately; no release pulse generated.
- Release accepted in the same cycle as long/rpt wrap would occur: release wins, long/rpt suppressed.

## Test plan
Params CHANNELS=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_HIGH=1.
- Clean press key[0]=1 before edge 1 -> level[0]=1 and press[0]=1 after edge 6; press[0] low after edge 7; channel 1 untouched.
- Bounce key[0] toggling every 3 cycles for 30 cycles then stable 1 -> no press during bounce; press 6 edges after last toggle.
- Hold key[0] 50 cycles after press with repeat_en[0]=1 -> long at +20, rpt at +28, +36, +44; release pulse DEBOUNCE_CYCLES+2 after key drops, no further rpt.
- Same hold with repeat_en[0]=0 except high during +30..+38 -> long at +20, single rpt at +36.
- Press both channels same cycle, release key[1] at +10 -> press[1:0]=11 same cycle; ch1 release, no long[1]; ch0 long at +20.
- rst_n low at +15 of hold, key held -> outputs 0 at once, no release; after rst_n high, press at +6, long 20 cycles later; repeat with ACTIVE_HIGH=0 and inverted stimulus for identical results.
